stereo_pixel_feeder: RTL and testbench



---
 rtl/stereo_pixel_feeder.sv | 171 +++++++++++++++++
 tb/tb_stereo_pixel_feeder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_pixel_feeder.sv
// Streams a stored left/right frame pair from two pixel RAMs as a line-timed raster to the stereo core.
// Latency: first image_hs rises max(hblank,1)+2 cycles after the start cycle; pixel data follows its read by 1 cycle.
// Backpressure: none; the core must accept one pixel per image_hs cycle, and start is ignored while busy.
module stereo_pixel_feeder #(
    parameter int ADDR_W = 22,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic [10:0]       width,
    input  logic [10:0]       height,
    input  logic [7:0]        hblank,
    input  logic [15:0]       vblank,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [PIX_W-1:0]  mem_data_l,
    input  logic [PIX_W-1:0]  mem_data_r,
    output logic              image_hs,
    output logic              v_end,
    output logic [PIX_W-1:0]  data_in_left,
    output logic [PIX_W-1:0]  data_in_right,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        HBLANK,
        ACTIVE,
        VBLANK
    } state_t;

    state_t      state;

    // Configuration latched at each frame start; live inputs are ignored mid-frame.
    logic [10:0] width_q;
    logic [10:0] height_q;
    logic [7:0]  hblank_q;
    logic [15:0] vblank_q;

    logic [10:0] x_cnt;
    logic [10:0] line_cnt;
    logic [7:0]  h_cnt;
    logic [15:0] v_cnt;

    // Last pixel seen on each side, held while image_hs is low.
    logic [PIX_W-1:0] hold_l;
    logic [PIX_W-1:0] hold_r;

    logic [7:0]  h_last;
    logic [15:0] v_last;
    logic        cfg_ok;

    // Terminal counts: a zero hblank still gives one blank cycle. VBLANK spends one
    // extra leading cycle while the final pixel drains out of the RAM, so the visible
    // blank (v_end high after the last pixel) lasts max(vblank,1) cycles.
    always_comb begin
        h_last = (hblank_q == 8'd0) ? 8'd0 : (hblank_q - 8'd1);
        v_last = (vblank_q == 16'd0) ? 16'd1 : vblank_q;
        cfg_ok = (width != 11'd0) && (height != 11'd0);
    end

    // Raster sequencer; all outputs except the pixel muxes are registered here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            width_q    <= 11'd0;
            height_q   <= 11'd0;
            hblank_q   <= 8'd0;
            vblank_q   <= 16'd0;
            x_cnt      <= 11'd0;
            line_cnt   <= 11'd0;
            h_cnt      <= 8'd0;
            v_cnt      <= 16'd0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            image_hs   <= 1'b0;
            v_end      <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
        end else begin
            image_hs   <= mem_rd;
            frame_done <= 1'b0;
            if (image_hs) begin
                hold_l <= mem_data_l;
                hold_r <= mem_data_r;
            end
            case (state)
                IDLE: begin
                    v_end  <= 1'b1;
                    busy   <= 1'b0;
                    mem_rd <= 1'b0;
                    if (start && cfg_ok) begin
                        width_q  <= width;
                        height_q <= height;
                        hblank_q <= hblank;
                        vblank_q <= vblank;
                        line_cnt <= 11'd0;
                        mem_addr <= '0;
                        h_cnt    <= 8'd0;
                        busy     <= 1'b1;
                        state    <= HBLANK;
                    end
                end
                HBLANK: begin
                    v_end <= 1'b0;
                    if (h_cnt == h_last) begin
                        x_cnt  <= 11'd0;
                        mem_rd <= 1'b1;
                        state  <= ACTIVE;
                    end else begin
                        h_cnt <= h_cnt + 8'd1;
                    end
                end
                ACTIVE: begin
                    if (x_cnt == (width_q - 11'd1)) begin
                        mem_rd <= 1'b0;
                        h_cnt  <= 8'd0;
                        if (line_cnt == (height_q - 11'd1)) begin
                            // Address parks on the final pixel of the frame.
                            v_cnt <= 16'd0;
                            state <= VBLANK;
                        end else begin
                            line_cnt <= line_cnt + 11'd1;
                            mem_addr <= mem_addr + ADDR_W'(1);
                            state    <= HBLANK;
                        end
                    end else begin
                        x_cnt    <= x_cnt + 11'd1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                VBLANK: begin
                    v_end      <= 1'b1;
                    frame_done <= (v_cnt == 16'd0);
                    if (v_cnt == v_last) begin
                        if (cont && cfg_ok) begin
                            width_q  <= width;
                            height_q <= height;
                            hblank_q <= hblank;
                            vblank_q <= vblank;
                            line_cnt <= 11'd0;
                            mem_addr <= '0;
                            h_cnt    <= 8'd0;
                            state    <= HBLANK;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        v_cnt <= v_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM data arrives in the same cycle as image_hs, so it is passed straight through.
    always_comb begin
        data_in_left  = image_hs ? mem_data_l : hold_l;
        data_in_right = image_hs ? mem_data_r : hold_r;
    end

endmodule

// File: tb/tb_stereo_pixel_feeder.sv
// Bench for stereo_pixel_feeder: table of frame configurations plus hand sequences.
// Pixel/address expectations go into scoreboard queues at start and are popped as the DUT reads/emits.
// RAM model returns addr[7:0] on the left and ~addr[7:0] on the right, one cycle after mem_rd.
module tb_stereo_pixel_feeder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cont;
    logic [10:0] width;
    logic [10:0] height;
    logic [7:0]  hblank;
    logic [15:0] vblank;
    logic [21:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data_l;
    logic [7:0]  mem_data_r;
    logic        image_hs;
    logic        v_end;
    logic [7:0]  data_in_left;
    logic [7:0]  data_in_right;
    logic        busy;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    int exp_addr_q[$];
    int exp_pix_q[$];

    typedef struct {
        int w;
        int h;
        int hb;
        int vb;
        bit use_cont;
        bit mid_start;
        int exp_pix;
        int exp_bursts;
        int exp_gap;
        int exp_lat;
        int exp_done_busy;
        int exp_frames;
    } vec_t;

    vec_t vecs[6];

    stereo_pixel_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cont         (cont),
        .width        (width),
        .height       (height),
        .hblank       (hblank),
        .vblank       (vblank),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data_l   (mem_data_l),
        .mem_data_r   (mem_data_r),
        .image_hs     (image_hs),
        .v_end        (v_end),
        .data_in_left (data_in_left),
        .data_in_right(data_in_right),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous pixel RAM pair.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data_l <= mem_addr[7:0];
            mem_data_r <= ~mem_addr[7:0];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n, pix, bursts, fd_cnt, fd_at, lat, vend_drop, busy_fall;
        int gap_len, gap_min, gap_max, e, last_l, last_r;
        bit prev_hs, in_gap, fd_in_gap;
        exp_addr_q.delete();
        exp_pix_q.delete();
        for (int f = 0; f < v.exp_frames; f++) begin
            for (int i = 0; i < v.w * v.h; i++) begin
                exp_addr_q.push_back(i);
                exp_pix_q.push_back(i);
            end
        end
        width  = 11'(v.w);
        height = 11'(v.h);
        hblank = 8'(v.hb);
        vblank = 16'(v.vb);
        cont   = v.use_cont;
        start  = 1'b1;
        tick();
        start = 1'b0;
        n = 1; pix = 0; bursts = 0; fd_cnt = 0; fd_at = -1; lat = -1;
        vend_drop = -1; busy_fall = -1; gap_len = 0; gap_min = 1 << 30; gap_max = -1;
        last_l = -1; last_r = -1;
        prev_hs = 1'b0; in_gap = 1'b0; fd_in_gap = 1'b0;
        while (n < 3000 && busy_fall < 0) begin
            if (mem_rd) begin
                if (exp_addr_q.size() == 0) chk($sformatf("v%0d_extra_read", idx), 1, 0);
                else chk($sformatf("v%0d_mem_addr", idx), mem_addr, exp_addr_q.pop_front());
            end
            if (image_hs) begin
                pix++;
                if (!prev_hs) begin
                    bursts++;
                    if (lat < 0) lat = n;
                    if (in_gap && !fd_in_gap) begin
                        if (gap_len < gap_min) gap_min = gap_len;
                        if (gap_len > gap_max) gap_max = gap_len;
                    end
                    in_gap = 1'b0;
                end
                if (exp_pix_q.size() == 0) begin
                    chk($sformatf("v%0d_extra_pixel", idx), 1, 0);
                end else begin
                    e = exp_pix_q.pop_front();
                    chk($sformatf("v%0d_data_left", idx), data_in_left, e & 255);
                    chk($sformatf("v%0d_data_right", idx), data_in_right, (~e) & 255);
                end
                last_l = data_in_left;
                last_r = data_in_right;
            end else begin
                if (prev_hs) begin
                    in_gap = 1'b1;
                    gap_len = 0;
                    fd_in_gap = 1'b0;
                    chk($sformatf("v%0d_hold_left", idx), data_in_left, last_l);
                    chk($sformatf("v%0d_hold_right", idx), data_in_right, last_r);
                end
                if (in_gap) gap_len++;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_at = n;
                fd_in_gap = 1'b1;
            end
            if (vend_drop < 0 && !v_end) vend_drop = n;
            if (!busy) busy_fall = n;
            // Mid-frame start plus a config change: both must be ignored.
            if (v.mid_start && n == 6) begin
                start = 1'b1;
                width = 11'd2;
            end else if (v.mid_start && n == 7) begin
                start = 1'b0;
                width = 11'(v.w);
            end
            if (v.use_cont && pix > v.w * v.h) cont = 1'b0;
            prev_hs = image_hs;
            tick();
            n++;
        end
        start = 1'b0;
        cont  = 1'b0;
        chk($sformatf("v%0d_busy_fell_in_budget", idx), busy_fall >= 0, 1);
        chk($sformatf("v%0d_pixels", idx), pix, v.exp_pix);
        chk($sformatf("v%0d_bursts", idx), bursts, v.exp_bursts);
        chk($sformatf("v%0d_first_hs_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_frame_done_count", idx), fd_cnt, v.exp_frames);
        chk($sformatf("v%0d_done_to_busy_low", idx), busy_fall - fd_at, v.exp_done_busy);
        chk($sformatf("v%0d_v_end_drop", idx), vend_drop, 2);
        chk($sformatf("v%0d_v_end_idle", idx), v_end, 1);
        chk($sformatf("v%0d_addr_q_empty", idx), exp_addr_q.size(), 0);
        if (v.exp_bursts > 1) begin
            chk($sformatf("v%0d_gap_min", idx), gap_min, v.exp_gap);
            chk($sformatf("v%0d_gap_max", idx), gap_max, v.exp_gap);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int b;
        //          w   h  hb  vb cont mid  pix bursts gap lat d2b frames
        vecs[0] = '{4,  3,  3,  5, 0,  0,   12, 3,     3,  5,  5,  1};
        vecs[1] = '{4,  3,  0,  0, 0,  0,   12, 3,     1,  3,  1,  1};
        vecs[2] = '{1,  1,  1,  2, 0,  0,   1,  1,     0,  3,  2,  1};
        vecs[3] = '{7,  2, 10,  3, 0,  1,   14, 2,     10, 12, 3,  1};
        vecs[4] = '{3,  2,  2,  4, 1,  0,   12, 4,     2,  4,  4,  2};
        vecs[5] = '{5,  4,  1,  1, 0,  0,   20, 4,     1,  3,  1,  1};

        rst = 1'b0; start = 1'b0; cont = 1'b0;
        width = 11'd0; height = 11'd0; hblank = 8'd0; vblank = 16'd0;
        tick();
        tick();
        chk("reset_image_hs", image_hs, 0);
        chk("reset_v_end", v_end, 1);
        chk("reset_mem_rd", mem_rd, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_data_left", data_in_left, 0);
        chk("reset_data_right", data_in_right, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Start with a zero dimension is dropped.
        width = 11'd0; height = 11'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("zero_width_busy", busy, 0);
            chk("zero_width_mem_rd", mem_rd, 0);
            tick();
        end
        chk("zero_width_v_end", v_end, 1);
        width = 11'd4; height = 11'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("zero_height_busy", busy, 0);

        // Reset pulse at the start of line 2 of a 4x3 frame.
        width = 11'd4; height = 11'd3; hblank = 8'd3; vblank = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        b = 0;
        for (int k = 0; k < 200 && b < 2; k++) begin
            if (image_hs && !dut.image_hs) b = b;
            tick();
            if (image_hs && mem_addr == 22'd5) b = 2;
        end
        chk("midline_reached", b, 2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midline_rst_image_hs", image_hs, 0);
        chk("midline_rst_v_end", v_end, 1);
        chk("midline_rst_mem_addr", mem_addr, 0);
        chk("midline_rst_mem_rd", mem_rd, 0);
        chk("midline_rst_busy", busy, 0);
        chk("midline_rst_data_left", data_in_left, 0);
        tick();
        run_vec(vecs[0], 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
